alu_issue_ctrl: RTL and testbench

//  Upstream issue/writeback controller for the combinational 8-bit ALU
//  (opcode, op1, op2 -> out, eflags).
//  - Accepts one instruction at a time over a valid/ready handshake.
//  - Reads operands from a small internal register file.
//  - Drives the ALU for exactly one cycle, then captures out/eflags.
//  - Writes the result back to the register file and updates the flags register.
//

---
 rtl/alu_pkg.sv | 14 +
 rtl/alu_issue_ctrl_if.sv | 37 +++
 rtl/alu_regfile.sv | 36 +++
 rtl/alu_issue_ctrl.sv | 130 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue/writeback controller.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WB
  } issue_state_t;

  localparam logic [7:0] OPC_NOP   = 8'd0;
  localparam int         NREGS_DEF = 4;
  localparam int         RIDX_DEF  = $clog2(NREGS_DEF);

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction offer channel: valid/ready plus decoded operand selects.
interface alu_issue_ctrl_if #(
  parameter int RIDX_W = 2
);

  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_opcode;
  logic [RIDX_W-1:0] in_rd;
  logic [RIDX_W-1:0] in_rs1;
  logic [RIDX_W-1:0] in_rs2;
  logic              in_imm_sel;
  logic [7:0]        in_imm;

  modport master (
    output in_valid,
    output in_opcode,
    output in_rd,
    output in_rs1,
    output in_rs2,
    output in_imm_sel,
    output in_imm,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_opcode,
    input  in_rd,
    input  in_rs1,
    input  in_rs2,
    input  in_imm_sel,
    input  in_imm,
    output in_ready
  );

endinterface

// File: rtl/alu_regfile.sv
// Small 8-bit register file: two operand reads, one debug read,
// one write port, async active-low clear.
module alu_regfile #(
  parameter int NREGS  = 4,
  parameter int RIDX_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [RIDX_W-1:0] waddr_i,
  input  logic [7:0]        wdata_i,
  input  logic [RIDX_W-1:0] raddr1_i,
  output logic [7:0]        rdata1_o,
  input  logic [RIDX_W-1:0] raddr2_i,
  output logic [7:0]        rdata2_o,
  input  logic [RIDX_W-1:0] dbg_addr_i,
  output logic [7:0]        dbg_data_o
);

  logic [7:0] regs_q [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o   = regs_q[raddr1_i];
  assign rdata2_o   = regs_q[raddr2_i];
  assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller around a combinational 8-bit ALU:
// one instruction in flight, two cycles per instruction.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int NREGS  = NREGS_DEF,
  parameter int RIDX_W = $clog2(NREGS),
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_issue_ctrl_if.slave   in_if,
  output logic [7:0]        alu_opcode,
  output logic [7:0]        alu_op1,
  output logic [7:0]        alu_op2,
  input  logic [7:0]        alu_out,
  input  logic [7:0]        alu_eflags,
  output logic [7:0]        flags,
  output logic              wb_valid,
  output logic [CNT_W-1:0]  retired,
  input  logic [RIDX_W-1:0] dbg_addr,
  output logic [7:0]        dbg_data
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  issue_state_t      state_q, state_d;
  logic [7:0]        opc_q;
  logic [RIDX_W-1:0] rd_q;
  logic [7:0]        op1_q;
  logic [7:0]        op2_q;
  logic [7:0]        flags_q;
  logic [CNT_W-1:0]  retired_q;

  logic              ready;
  logic              accept;
  logic              in_issue;
  logic              wr_en;
  logic [7:0]        rs1_data;
  logic [7:0]        rs2_data;

  assign accept = in_if.in_valid & ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = accept ? ISSUE : IDLE;
      ISSUE:   state_d = WB;
      WB:      state_d = accept ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready    = 1'b1;
    wb_valid = 1'b0;
    in_issue = 1'b0;
    unique case (state_q)
      IDLE:  ready = 1'b1;
      ISSUE: begin
        ready    = 1'b0;
        in_issue = 1'b1;
      end
      WB:    wb_valid = 1'b1;
      default: ready = 1'b1;
    endcase
  end

  // NOPs retire and pulse wb_valid but leave regs and flags alone
  assign wr_en = in_issue & (opc_q != OPC_NOP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opc_q <= '0;
      rd_q  <= '0;
      op1_q <= '0;
      op2_q <= '0;
    end else if (accept) begin
      opc_q <= in_if.in_opcode;
      rd_q  <= in_if.in_rd;
      op1_q <= rs1_data;
      op2_q <= in_if.in_imm_sel ? in_if.in_imm : rs2_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q   <= '0;
      retired_q <= '0;
    end else if (in_issue) begin
      retired_q <= retired_q + CNT_ONE;
      if (wr_en) begin
        flags_q <= alu_eflags;
      end
    end
  end

  alu_regfile #(
    .NREGS  (NREGS),
    .RIDX_W (RIDX_W)
  ) u_rf (
    .clk        (clk),
    .rst_n      (rst_n),
    .we_i       (wr_en),
    .waddr_i    (rd_q),
    .wdata_i    (alu_out),
    .raddr1_i   (in_if.in_rs1),
    .rdata1_o   (rs1_data),
    .raddr2_i   (in_if.in_rs2),
    .rdata2_o   (rs2_data),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
  );

  assign in_if.in_ready = ready;
  assign alu_opcode     = opc_q;
  assign alu_op1        = op1_q;
  assign alu_op2        = op2_q;
  assign flags          = flags_q;
  assign retired        = retired_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed table, corner sequences and a
// randomized run against a transaction-level model.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  alu_opcode, alu_op1, alu_op2;
  logic [7:0]  alu_out, alu_eflags;
  logic [7:0]  flags;
  logic        wb_valid;
  logic [15:0] retired;
  logic [1:0]  dbg_addr;
  logic [7:0]  dbg_data;

  int n_pass  = 0;
  int n_total = 0;

  alu_issue_ctrl_if #(.RIDX_W(2)) ifc ();

  alu_issue_ctrl #(.NREGS(4), .RIDX_W(2), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_if      (ifc.slave),
    .alu_opcode (alu_opcode),
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
    .alu_out    (alu_out),
    .alu_eflags (alu_eflags),
    .flags      (flags),
    .wb_valid   (wb_valid),
    .retired    (retired),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  always #5 clk = ~clk;

  // ALU: eflags = {5'b0, sign, carry/borrow, zero}
  function automatic logic [15:0] alu_f(logic [7:0] opc, logic [7:0] a, logic [7:0] b);
    logic [8:0] r;
    r = '0;
    case (opc)
      8'd1: r = {1'b0, a} + {1'b0, b};
      8'd2: r = {(a < b), a - b};
      8'd3: r = {1'b0, a & b};
      8'd4: r = {1'b0, a | b};
      8'd5: r = {1'b0, a ^ b};
      8'd6: r = {1'b0, a};
      8'd7: r = {1'b0, b};
      default: r = '0;
    endcase
    return {r[7:0], 5'b0, r[7], r[8], (r[7:0] == 8'd0)};
  endfunction

  always_comb {alu_out, alu_eflags} = alu_f(alu_opcode, alu_op1, alu_op2);

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [7:0] opc;
    logic [1:0] rd, rs1, rs2;
    logic       isel;
    logic [7:0] imm, op1, op2, res, flg;
  } vec_t;

  vec_t tbl [8];

  task automatic drive(logic [7:0] opc, logic [1:0] rd, logic [1:0] rs1,
                       logic [1:0] rs2, logic isel, logic [7:0] imm);
    ifc.in_valid   = 1'b1;
    ifc.in_opcode  = opc;
    ifc.in_rd      = rd;
    ifc.in_rs1     = rs1;
    ifc.in_rs2     = rs2;
    ifc.in_imm_sel = isel;
    ifc.in_imm     = imm;
  endtask

  // reference model state for the random run
  logic [7:0]  m_regs [4];
  logic [7:0]  m_flags;
  logic [15:0] m_ret;
  logic        m_busy, m_wb, m_acc, m_hold;
  logic [7:0]  m_opc, m_op1, m_op2;
  logic [1:0]  m_rd;
  logic [15:0] m_r;

  initial begin
    tbl[0] = '{8'd7, 2'd0, 2'd0, 2'd0, 1'b1, 8'h03, 8'h00, 8'h03, 8'h03, 8'h00};
    tbl[1] = '{8'd1, 2'd1, 2'd0, 2'd0, 1'b1, 8'hFD, 8'h03, 8'hFD, 8'h00, 8'h03};
    tbl[2] = '{8'd2, 2'd2, 2'd0, 2'd1, 1'b0, 8'h00, 8'h03, 8'h00, 8'h03, 8'h00};
    tbl[3] = '{8'd4, 2'd3, 2'd2, 2'd0, 1'b1, 8'h80, 8'h03, 8'h80, 8'h83, 8'h04};
    tbl[4] = '{8'd5, 2'd0, 2'd3, 2'd3, 1'b0, 8'h00, 8'h83, 8'h83, 8'h00, 8'h01};
    tbl[5] = '{8'd2, 2'd1, 2'd0, 2'd0, 1'b1, 8'h01, 8'h00, 8'h01, 8'hFF, 8'h06};
    tbl[6] = '{8'd0, 2'd3, 2'd1, 2'd2, 1'b0, 8'h00, 8'hFF, 8'h03, 8'h83, 8'h06};
    tbl[7] = '{8'd3, 2'd2, 2'd1, 2'd3, 1'b0, 8'h00, 8'hFF, 8'h83, 8'h83, 8'h04};

    rst_n          = 1'b0;
    ifc.in_valid   = 1'b0;
    ifc.in_opcode  = '0;
    ifc.in_rd      = '0;
    ifc.in_rs1     = '0;
    ifc.in_rs2     = '0;
    ifc.in_imm_sel = 1'b0;
    ifc.in_imm     = '0;
    dbg_addr       = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", ifc.in_ready, 1);
    chk("rst_flags", flags, 0);
    chk("rst_retired", retired, 0);
    chk("rst_wb", wb_valid, 0);
    chk("rst_aluop1", alu_op1, 0);

    // directed table, one instruction at a time
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].opc, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].isel, tbl[i].imm);
      dbg_addr = tbl[i].rd;
      @(negedge clk);
      ifc.in_valid = 1'b0;
      chk($sformatf("v%0d_ready_issue", i), ifc.in_ready, 0);
      chk($sformatf("v%0d_wb_issue", i), wb_valid, 0);
      chk($sformatf("v%0d_opcode", i), alu_opcode, tbl[i].opc);
      chk($sformatf("v%0d_op1", i), alu_op1, tbl[i].op1);
      chk($sformatf("v%0d_op2", i), alu_op2, tbl[i].op2);
      @(negedge clk);
      chk($sformatf("v%0d_wb", i), wb_valid, 1);
      chk($sformatf("v%0d_res", i), dbg_data, tbl[i].res);
      chk($sformatf("v%0d_flags", i), flags, tbl[i].flg);
      chk($sformatf("v%0d_ret", i), retired, i + 1);
      @(negedge clk);
      chk($sformatf("v%0d_wb_after", i), wb_valid, 0);
    end

    // back-to-back with valid held high, accepted in each WB cycle
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: drive(8'd1, 2'd1, 2'd1, 2'd0, 1'b1, 8'h01);
        1: drive(8'd2, 2'd1, 2'd1, 2'd0, 1'b1, 8'h10);
        2: drive(8'd4, 2'd0, 2'd1, 2'd0, 1'b1, 8'h0F);
        default: drive(8'd5, 2'd1, 2'd0, 2'd1, 1'b0, 8'h00);
      endcase
      @(negedge clk);
      chk($sformatf("b2b%0d_ready_issue", k), ifc.in_ready, 0);
      @(negedge clk);
      chk($sformatf("b2b%0d_ready_wb", k), ifc.in_ready, 1);
      chk($sformatf("b2b%0d_wb", k), wb_valid, 1);
    end
    ifc.in_valid = 1'b0;
    chk("b2b_retired", retired, 12);
    chk("b2b_r3_kept", tbl[3].res, 8'h83);

    // RAW: B accepted in A's WB reads A's freshly written result
    drive(8'd7, 2'd2, 2'd0, 2'd0, 1'b1, 8'h55);
    @(negedge clk);
    @(negedge clk);
    drive(8'd1, 2'd0, 2'd2, 2'd0, 1'b1, 8'h01);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    chk("raw_op1", alu_op1, 8'h55);
    @(negedge clk);
    dbg_addr = 2'd0;
    #1;
    chk("raw_res", dbg_data, 8'h56);
    chk("raw_flags", flags, 8'h00);

    // NOP leaves r3 and flags alone but still retires
    @(negedge clk);
    drive(8'd0, 2'd3, 2'd1, 2'd1, 1'b1, 8'hAA);
    dbg_addr = 2'd3;
    @(negedge clk);
    ifc.in_valid = 1'b0;
    @(negedge clk);
    chk("nop_wb", wb_valid, 1);
    chk("nop_r3", dbg_data, 8'h83);
    chk("nop_flags", flags, 8'h00);
    chk("nop_ret", retired, 15);
    @(negedge clk);
    chk("nop_wb_after", wb_valid, 0);

    // reset mid-run clears everything
    rst_n = 1'b0;
    #2;
    chk("mid_rst_flags", flags, 0);
    chk("mid_rst_ret", retired, 0);
    for (int r = 0; r < 4; r++) begin
      dbg_addr = 2'(r);
      #0.1;
      chk($sformatf("mid_rst_r%0d", r), dbg_data, 0);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", ifc.in_ready, 1);

    // reset during ISSUE drops the instruction; held valid re-accepted
    drive(8'd7, 2'd1, 2'd0, 2'd0, 1'b1, 8'h42);
    dbg_addr = 2'd1;
    @(negedge clk);
    chk("ri_issue", ifc.in_ready, 0);
    rst_n = 1'b0;
    #2;
    chk("ri_ret", retired, 0);
    chk("ri_r1", dbg_data, 0);
    chk("ri_ready", ifc.in_ready, 1);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ri_reissue", ifc.in_ready, 0);
    chk("ri_ret_issue", retired, 0);
    ifc.in_valid = 1'b0;
    @(negedge clk);
    chk("ri_wb", wb_valid, 1);
    chk("ri_r1_wb", dbg_data, 8'h42);
    chk("ri_ret_wb", retired, 1);

    // randomized run against a one-slot transaction model
    rst_n = 1'b0;
    ifc.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < 4; r++) m_regs[r] = '0;
    m_flags = '0;
    m_ret   = '0;
    m_busy  = 1'b0;
    m_opc   = '0;
    m_op1   = '0;
    m_op2   = '0;
    m_rd    = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      m_acc = ifc.in_valid && !m_busy;
      m_wb  = 1'b0;
      if (m_busy) begin
        m_r = alu_f(m_opc, m_op1, m_op2);
        if (m_opc != 8'd0) begin
          m_regs[m_rd] = m_r[15:8];
          m_flags      = m_r[7:0];
        end
        m_ret  = m_ret + 16'd1;
        m_wb   = 1'b1;
        m_busy = 1'b0;
      end else if (m_acc) begin
        m_busy = 1'b1;
        m_opc  = ifc.in_opcode;
        m_rd   = ifc.in_rd;
        m_op1  = m_regs[ifc.in_rs1];
        m_op2  = ifc.in_imm_sel ? ifc.in_imm : m_regs[ifc.in_rs2];
      end
      dbg_addr = 2'($urandom_range(0, 3));
      #1;
      chk("rnd_ready", ifc.in_ready, !m_busy);
      chk("rnd_wb", wb_valid, m_wb);
      chk("rnd_flags", flags, m_flags);
      chk("rnd_ret", retired, m_ret);
      chk("rnd_dbg", dbg_data, m_regs[dbg_addr]);
      if (m_busy) begin
        chk("rnd_op1", alu_op1, m_op1);
        chk("rnd_op2", alu_op2, m_op2);
        chk("rnd_opc", alu_opcode, m_opc);
      end
      m_hold = ifc.in_valid && m_busy && !m_acc;
      if (!m_hold) begin
        ifc.in_valid = ($urandom_range(0, 3) != 0);
        ifc.in_opcode  = 8'($urandom_range(0, 7));
        ifc.in_rd      = 2'($urandom_range(0, 3));
        ifc.in_rs1     = 2'($urandom_range(0, 3));
        ifc.in_rs2     = 2'($urandom_range(0, 3));
        ifc.in_imm_sel = 1'($urandom_range(0, 1));
        ifc.in_imm     = 8'($urandom);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
